mips_mc_control: RTL and testbench
==================================

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 Parameter TIMEOUT_W, default 8: width of the memory-wait watchdog counter.
REQ-002 Parameter TRAP_ILLEGAL, default 1: 1 = illegal opcode/funct halts; 0 = retired as NOP.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 op, funct  in  6 each  instruction fields from the instruction register.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  unified memory has completed the current request this cycle.
REQ-009 memreq, memwe, iord  out  1 each  memory request, write enable, data address (1) vs PC (0).
REQ-010 irwrite, pcen, regwrite, regdst, memtoreg, link  out  1 each  datapath enables and selects; link forces write address 31 and write data PC.
REQ-011 alusrca  out  1, alusrcb  out  2, pcsrc  out  2  (alusrcb: 00 reg, 01 const 4, 10 ext imm, 11 ext imm<<2; pcsrc: 00 ALU result, 01 ALUOut reg, 10 jump target, 11 rs).
REQ-012 signext, shiftl16  out  1 each; alucontrol  out  4 (0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1111 sltu).
REQ-013 halted, fault  out  1 each; state  out  4  debug view of the current state.

Function
REQ-014 States SHALL be FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, ALUWB 7, BRANCH 8, IEXEC 9, JUMP 10, JAL 11, JR 12, HALT 15.
REQ-015 FETCH: memreq=1, iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00; irwrite and pcen SHALL be 1 only in the cycle mem_ready=1, and the FSM then moves to DECODE; otherwise it stays in FETCH.
REQ-016 DECODE: alusrca=0, alusrcb=11, signext=1, alucontrol=add, latching the branch target. Next state by op: 100011/101011->MEMADR; 000000->RTEXEC, or JR if funct=001000; 000100/000101->BRANCH; 001000/001001/001101/001111->IEXEC; 000010->JUMP; 000011->JAL; any other->illegal.
REQ-017 MEMADR: alusrca=1, alusrcb=10, signext=1, add; next MEMRD if op=100011, else MEMWR.
REQ-018 MEMRD/MEMWR: memreq=1, iord=1, memwe=1 only in MEMWR; hold until mem_ready=1, then MEMRD->MEMWB and MEMWR->FETCH.
REQ-019 MEMWB: regwrite=1, regdst=0, memtoreg=1; ->FETCH.
REQ-020 RTEXEC: alusrca=1, alusrcb=00, alucontrol from funct (100000/100001 add, 100010/100011 sub, 100100 and, 100101 or, 101010 slt, 101011 sltu); ->ALUWB. ALUWB: regwrite=1, regdst=1; ->FETCH.
REQ-021 IEXEC: alusrca=1, alusrcb=10; ADDI/ADDIU signext=1 add; ORI signext=0 or; LUI shiftl16=1 add; the next cycle writes rt (regwrite=1, regdst=0), then ->FETCH (IEXEC SHALL be two cycles, tracked by an internal phase bit).
REQ-022 BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=(op[0] XOR zero); ->FETCH.
REQ-023 JUMP: pcsrc=10, pcen=1. JAL: same, plus regwrite=1, link=1. JR: pcsrc=11, pcen=1. All three ->FETCH.
REQ-024 Unrecognised funct in RTEXEC/DECODE SHALL count as illegal. With TRAP_ILLEGAL=1, illegal->HALT with fault=0; with TRAP_ILLEGAL=0, illegal->FETCH with no writes.
REQ-025 The watchdog SHALL clear on entry to each memory state, increment each cycle mem_ready=0, and on reaching 2^TIMEOUT_W-1 force HALT with fault=1; mem_ready=1 in that same cycle wins (normal transition).
REQ-026 HALT: all enables 0, halted=1, sticky until reset.
REQ-027 All enable outputs (memreq, memwe, irwrite, pcen, regwrite) SHALL be 0 in every state not listed as asserting them; outputs are combinational from state, op, funct, zero, and mem_ready.

Reset
REQ-028 reset SHALL force FETCH, clear the watchdog and phase bit, and clear halted/fault immediately (asynchronously), including mid-memory-wait; the first fetch memreq is asserted in the cycle reset deasserts.

Verification
REQ-029 LW with mem_ready delayed 3 cycles in FETCH and 2 in MEMRD -> states 0,0,0,0,1,2,3,3,3,4,0; regwrite=1 only in MEMWB.
REQ-030 BNE (op=000101) with zero=0 -> pcen=1, pcsrc=01 in BRANCH; BEQ with zero=0 -> pcen=0.
REQ-031 JAL -> state 11 with pcen=1, regwrite=1, link=1, pcsrc=10; R-type funct=001000 -> state 12 with pcsrc=11.
REQ-032 TIMEOUT_W=3, mem_ready held 0 in FETCH -> HALT after 7 waiting cycles with fault=1, halted=1; mem_ready=1 on cycle 7 -> DECODE instead.
REQ-033 op=111111: TRAP_ILLEGAL=1 -> HALT, fault=0; TRAP_ILLEGAL=0 -> FETCH with regwrite=0, memwe=0.
REQ-034 Reset asserted during MEMWR wait -> state=0, memwe=0, halted=0 before the next clock edge.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over a unified memory,
// with a memory-wait watchdog and optional trapping of illegal instructions.
module mips_mc_control #(
  parameter int unsigned TIMEOUT_W    = 8,
  parameter bit          TRAP_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memreq,
  output logic       memwe,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       link,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       signext,
  output logic       shiftl16,
  output logic [3:0] alucontrol,
  output logic       halted,
  output logic       fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  RTEXEC = 4'd6,  ALUWB = 4'd7,
    BRANCH = 4'd8,  IEXEC  = 4'd9,  JUMP   = 4'd10, JAL   = 4'd11,
    JR     = 4'd12, HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [TIMEOUT_W-1:0] WD_LAST  = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam state_t               ILL_NEXT = TRAP_ILLEGAL ? HALT : FETCH;

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] wd_q;
  logic                 phase_q;
  logic                 fault_q;
  logic                 funct_ok;
  logic [3:0]           funct_alu;
  logic                 mem_state;
  logic                 wd_expire;

  // R-type funct to ALU operation; unknown functs are flagged illegal
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000, 6'b100001: funct_alu = ALU_ADD;
      6'b100010, 6'b100011: funct_alu = ALU_SUB;
      6'b100100:            funct_alu = ALU_AND;
      6'b100101:            funct_alu = ALU_OR;
      6'b101010:            funct_alu = ALU_SLT;
      6'b101011:            funct_alu = ALU_SLTU;
      default:              funct_ok  = 1'b0;
    endcase
  end

  // A completing access in the last watchdog cycle still wins
  assign mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign wd_expire = mem_state && !mem_ready && (wd_q == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      wd_q    <= '0;
      phase_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= (state_q == IEXEC) && !phase_q;
      fault_q <= fault_q | wd_expire;
      if (state_d != state_q)
        wd_q <= '0;
      else if (mem_state && !mem_ready)
        wd_q <= wd_q + TIMEOUT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    memreq     = 1'b0;
    memwe      = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    link       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    signext    = 1'b0;
    shiftl16   = 1'b0;
    alucontrol = ALU_AND;
    halted     = 1'b0;
    case (state_q)
      FETCH: begin
        memreq     = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcen    = 1'b1;
          state_d = DECODE;
        end else if (wd_expire) begin
          state_d = HALT;
        end
      end
      DECODE: begin
        alusrcb    = 2'b11;
        signext    = 1'b1;
        alucontrol = ALU_ADD;
        case (op)
          OP_LW, OP_SW:   state_d = MEMADR;
          OP_RTYPE:       state_d = (funct == FN_JR) ? JR : (funct_ok ? RTEXEC : ILL_NEXT);
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: state_d = IEXEC;
          OP_J:           state_d = JUMP;
          OP_JAL:         state_d = JAL;
          default:        state_d = ILL_NEXT;
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        signext    = 1'b1;
        alucontrol = ALU_ADD;
        state_d    = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD, MEMWR: begin
        memreq = 1'b1;
        iord   = 1'b1;
        memwe  = (state_q == MEMWR);
        if (mem_ready)
          state_d = (state_q == MEMRD) ? MEMWB : FETCH;
        else if (wd_expire)
          state_d = HALT;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = FETCH;
      end
      RTEXEC: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
        state_d    = funct_ok ? ALUWB : ILL_NEXT;
      end
      ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = op[0] ^ zero;
        state_d    = FETCH;
      end
      // Phase 0 computes into ALUOut, phase 1 writes rt
      IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op)
          OP_ORI:  alucontrol = ALU_OR;
          OP_LUI: begin
            shiftl16   = 1'b1;
            alucontrol = ALU_ADD;
          end
          default: begin
            signext    = 1'b1;
            alucontrol = ALU_ADD;
          end
        endcase
        if (phase_q) begin
          regwrite = 1'b1;
          state_d  = FETCH;
        end
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_d = FETCH;
      end
      JAL: begin
        pcsrc    = 2'b10;
        pcen     = 1'b1;
        regwrite = 1'b1;
        link     = 1'b1;
        state_d  = FETCH;
      end
      JR: begin
        pcsrc   = 2'b11;
        pcen    = 1'b1;
        state_d = FETCH;
      end
      HALT:    halted  = 1'b1;
      default: state_d = FETCH;
    endcase
  end

  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: a driver queues hand-computed control words,
// a negedge monitor compares them against two DUTs (trapping and non-trapping).
module tb_mips_mc_control;

  typedef struct packed {
    logic [3:0] st;
    logic       memreq, memwe, irwrite, pcen, regwrite, halted, fault;
    logic       iord, regdst, memtoreg, link, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       signext, shiftl16;
    logic [3:0] aluc;
  } ctl_t;

  localparam int K_FETCH = 0, K_DECODE = 1, K_MEMADR = 2, K_MEMRD = 3, K_MEMWB = 4,
                 K_MEMWR = 5, K_RTEXEC = 6, K_ALUWB = 7, K_BRANCH = 8, K_IADD = 9,
                 K_IOR = 10, K_ILUI = 11, K_IWB = 12, K_JUMP = 13, K_JAL = 14,
                 K_JR = 15, K_HALT = 16;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                         BNE = 6'b000101, ADDI = 6'b001000, ORI = 6'b001101, LUI = 6'b001111,
                         J = 6'b000010, JAL = 6'b000011, BAD = 6'b111111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] op = '0, funct = '0;
  logic zero = 1'b0, mem_ready = 1'b0;

  logic a_memreq, a_memwe, a_iord, a_irwrite, a_pcen, a_regwrite, a_regdst, a_memtoreg, a_link;
  logic a_alusrca, a_signext, a_shiftl16, a_halted, a_fault;
  logic [1:0] a_alusrcb, a_pcsrc;
  logic [3:0] a_alucontrol, a_state;
  logic b_memreq, b_memwe, b_iord, b_irwrite, b_pcen, b_regwrite, b_regdst, b_memtoreg, b_link;
  logic b_alusrca, b_signext, b_shiftl16, b_halted, b_fault;
  logic [1:0] b_alusrcb, b_pcsrc;
  logic [3:0] b_alucontrol, b_state;

  mips_mc_control #(.TIMEOUT_W(3), .TRAP_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .memreq(a_memreq), .memwe(a_memwe), .iord(a_iord), .irwrite(a_irwrite), .pcen(a_pcen),
    .regwrite(a_regwrite), .regdst(a_regdst), .memtoreg(a_memtoreg), .link(a_link),
    .alusrca(a_alusrca), .alusrcb(a_alusrcb), .pcsrc(a_pcsrc), .signext(a_signext),
    .shiftl16(a_shiftl16), .alucontrol(a_alucontrol), .halted(a_halted), .fault(a_fault),
    .state(a_state));

  mips_mc_control #(.TIMEOUT_W(3), .TRAP_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .memreq(b_memreq), .memwe(b_memwe), .iord(b_iord), .irwrite(b_irwrite), .pcen(b_pcen),
    .regwrite(b_regwrite), .regdst(b_regdst), .memtoreg(b_memtoreg), .link(b_link),
    .alusrca(b_alusrca), .alusrcb(b_alusrcb), .pcsrc(b_pcsrc), .signext(b_signext),
    .shiftl16(b_shiftl16), .alucontrol(b_alucontrol), .halted(b_halted), .fault(b_fault),
    .state(b_state));

  ctl_t act_a, act_b;
  assign act_a = {a_state, a_memreq, a_memwe, a_irwrite, a_pcen, a_regwrite, a_halted, a_fault,
                  a_iord, a_regdst, a_memtoreg, a_link, a_alusrca, a_alusrcb, a_pcsrc,
                  a_signext, a_shiftl16, a_alucontrol};
  assign act_b = {b_state, b_memreq, b_memwe, b_irwrite, b_pcen, b_regwrite, b_halted, b_fault,
                  b_iord, b_regdst, b_memtoreg, b_link, b_alusrca, b_alusrcb, b_pcsrc,
                  b_signext, b_shiftl16, b_alucontrol};

  always #5 clk = ~clk;

  ctl_t  q_exp[$];
  ctl_t  q_mask[$];
  string q_name[$];
  bit    q_sel[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic ctl_t mk(input logic [3:0] st, input logic [6:0] en, input logic [4:0] s1,
                              input logic [1:0] sb, input logic [1:0] ps, input logic [1:0] ex,
                              input logic [3:0] al);
    return ctl_t'({st, en, s1, sb, ps, ex, al});
  endfunction

  // en = {memreq, memwe, irwrite, pcen, regwrite, halted, fault}
  // s1 = {iord, regdst, memtoreg, link, alusrca}, ex = {signext, shiftl16}
  function automatic ctl_t exp_e(input int k, input logic [3:0] p);
    case (k)
      K_FETCH:  return mk(4'd0,  {2'b10, p[0], p[0], 3'b000}, 5'b00000, 2'b01, 2'b00, 2'b00, 4'b0010);
      K_DECODE: return mk(4'd1,  7'b0, 5'b00000, 2'b11, 2'b00, 2'b10, 4'b0010);
      K_MEMADR: return mk(4'd2,  7'b0, 5'b00001, 2'b10, 2'b00, 2'b10, 4'b0010);
      K_MEMRD:  return mk(4'd3,  7'b1000000, 5'b10000, 2'b00, 2'b00, 2'b00, 4'b0);
      K_MEMWB:  return mk(4'd4,  7'b0000100, 5'b00100, 2'b00, 2'b00, 2'b00, 4'b0);
      K_MEMWR:  return mk(4'd5,  7'b1100000, 5'b10000, 2'b00, 2'b00, 2'b00, 4'b0);
      K_RTEXEC: return mk(4'd6,  7'b0, 5'b00001, 2'b00, 2'b00, 2'b00, p);
      K_ALUWB:  return mk(4'd7,  7'b0000100, 5'b01000, 2'b00, 2'b00, 2'b00, 4'b0);
      K_BRANCH: return mk(4'd8,  {3'b000, p[0], 3'b000}, 5'b00001, 2'b00, 2'b01, 2'b00, 4'b0110);
      K_IADD:   return mk(4'd9,  7'b0, 5'b00001, 2'b10, 2'b00, 2'b10, 4'b0010);
      K_IOR:    return mk(4'd9,  7'b0, 5'b00001, 2'b10, 2'b00, 2'b00, 4'b0001);
      K_ILUI:   return mk(4'd9,  7'b0, 5'b00001, 2'b10, 2'b00, 2'b01, 4'b0010);
      K_IWB:    return mk(4'd9,  7'b0000100, 5'b00000, 2'b00, 2'b00, 2'b00, 4'b0);
      K_JUMP:   return mk(4'd10, 7'b0001000, 5'b00000, 2'b00, 2'b10, 2'b00, 4'b0);
      K_JAL:    return mk(4'd11, 7'b0001100, 5'b00010, 2'b00, 2'b10, 2'b00, 4'b0);
      K_JR:     return mk(4'd12, 7'b0001000, 5'b00000, 2'b00, 2'b11, 2'b00, 4'b0);
      default:  return mk(4'd15, {5'b00000, 1'b1, p[0]}, 5'b00000, 2'b00, 2'b00, 2'b00, 4'b0);
    endcase
  endfunction

  // Which fields each state actually defines; the rest are don't-care
  function automatic ctl_t exp_m(input int k);
    case (k)
      K_FETCH:                  return mk(4'hF, 7'h7F, 5'b10001, 2'b11, 2'b11, 2'b00, 4'hF);
      K_DECODE, K_MEMADR:       return mk(4'hF, 7'h7F, 5'b00001, 2'b11, 2'b00, 2'b10, 4'hF);
      K_MEMRD, K_MEMWR:         return mk(4'hF, 7'h7F, 5'b10000, 2'b00, 2'b00, 2'b00, 4'h0);
      K_MEMWB:                  return mk(4'hF, 7'h7F, 5'b01100, 2'b00, 2'b00, 2'b00, 4'h0);
      K_RTEXEC:                 return mk(4'hF, 7'h7F, 5'b00001, 2'b11, 2'b00, 2'b00, 4'hF);
      K_ALUWB, K_IWB:           return mk(4'hF, 7'h7F, 5'b01000, 2'b00, 2'b00, 2'b00, 4'h0);
      K_BRANCH:                 return mk(4'hF, 7'h7F, 5'b00001, 2'b11, 2'b11, 2'b00, 4'hF);
      K_IADD, K_IOR:            return mk(4'hF, 7'h7F, 5'b00001, 2'b11, 2'b00, 2'b10, 4'hF);
      K_ILUI:                   return mk(4'hF, 7'h7F, 5'b00001, 2'b11, 2'b00, 2'b01, 4'hF);
      K_JUMP, K_JR:             return mk(4'hF, 7'h7F, 5'b00000, 2'b00, 2'b11, 2'b00, 4'h0);
      K_JAL:                    return mk(4'hF, 7'h7F, 5'b00010, 2'b00, 2'b11, 2'b00, 4'h0);
      default:                  return mk(4'hF, 7'h7F, 5'b00000, 2'b00, 2'b00, 2'b00, 4'h0);
    endcase
  endfunction

  task automatic push(input string nm, input bit sel, input int k, input logic [3:0] p);
    q_name.push_back(nm);
    q_sel.push_back(sel);
    q_exp.push_back(exp_e(k, p));
    q_mask.push_back(exp_m(k));
  endtask

  // Called just after a rising edge: drive this cycle's inputs, queue dut_a's expected word
  task automatic step(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r,
                      input string nm, input int k, input logic [3:0] p);
    op = o; funct = f; zero = z; mem_ready = r;
    push(nm, 1'b0, k, p);
    @(posedge clk); #1;
  endtask

  // Asynchronous reset mid-cycle; both DUTs must show FETCH before the next edge
  task automatic do_reset(input string nm);
    mem_ready = 1'b0;
    reset = 1'b1;
    push(nm, 1'b0, K_FETCH, 4'd0);
    push(nm, 1'b1, K_FETCH, 4'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    while (q_exp.size() != 0) begin
      string nm;
      bit    sel;
      ctl_t  e, m, a;
      nm = q_name.pop_front();
      sel = q_sel.pop_front();
      e = q_exp.pop_front();
      m = q_mask.pop_front();
      a = sel ? act_b : act_a;
      n_cmp++;
      if ((a & m) !== (e & m)) begin
        n_bad++;
        $display("FAIL %s (dut_%s): got %07h want %07h mask %07h", nm, sel ? "b" : "a", a, e, m);
      end
    end
  end

  logic [5:0] fn_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b101011};
  logic [3:0] al_tab [6] = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111,   4'b1111};

  initial begin
    @(posedge clk); #1;
    do_reset("reset_state");

    // LW with 3 fetch waits and 2 read waits
    for (int i = 0; i < 3; i++) step(LW, 0, 0, 0, "lw_fetch_wait", K_FETCH, 4'd0);
    step(LW, 0, 0, 1, "lw_fetch_done", K_FETCH, 4'd1);
    step(LW, 0, 0, 0, "lw_decode", K_DECODE, 0);
    step(LW, 0, 0, 0, "lw_memadr", K_MEMADR, 0);
    step(LW, 0, 0, 0, "lw_memrd_wait", K_MEMRD, 0);
    step(LW, 0, 0, 0, "lw_memrd_wait", K_MEMRD, 0);
    step(LW, 0, 0, 1, "lw_memrd_done", K_MEMRD, 0);
    step(LW, 0, 0, 0, "lw_memwb", K_MEMWB, 0);

    // SW
    step(SW, 0, 0, 1, "sw_fetch", K_FETCH, 4'd1);
    step(SW, 0, 0, 0, "sw_decode", K_DECODE, 0);
    step(SW, 0, 0, 0, "sw_memadr", K_MEMADR, 0);
    step(SW, 0, 0, 0, "sw_memwr_wait", K_MEMWR, 0);
    step(SW, 0, 0, 1, "sw_memwr_done", K_MEMWR, 0);

    // R-type ALU ops
    for (int i = 0; i < 6; i++) begin
      step(RT, fn_tab[i], 0, 1, "rt_fetch", K_FETCH, 4'd1);
      step(RT, fn_tab[i], 0, 0, "rt_decode", K_DECODE, 0);
      step(RT, fn_tab[i], 0, 0, "rt_exec", K_RTEXEC, al_tab[i]);
      step(RT, fn_tab[i], 0, 0, "rt_aluwb", K_ALUWB, 0);
    end

    // Branches: taken iff op[0] xor zero
    step(BNE, 0, 0, 1, "bne_fetch", K_FETCH, 4'd1);
    step(BNE, 0, 0, 0, "bne_decode", K_DECODE, 0);
    step(BNE, 0, 0, 0, "bne_z0_taken", K_BRANCH, 4'd1);
    step(BEQ, 0, 0, 1, "beq_fetch", K_FETCH, 4'd1);
    step(BEQ, 0, 0, 0, "beq_decode", K_DECODE, 0);
    step(BEQ, 0, 0, 0, "beq_z0_not", K_BRANCH, 4'd0);
    step(BEQ, 0, 1, 1, "beq_fetch", K_FETCH, 4'd1);
    step(BEQ, 0, 1, 0, "beq_decode", K_DECODE, 0);
    step(BEQ, 0, 1, 0, "beq_z1_taken", K_BRANCH, 4'd1);

    // Immediates: two IEXEC cycles each
    step(ADDI, 0, 0, 1, "addi_fetch", K_FETCH, 4'd1);
    step(ADDI, 0, 0, 0, "addi_decode", K_DECODE, 0);
    step(ADDI, 0, 0, 0, "addi_exec", K_IADD, 0);
    step(ADDI, 0, 0, 0, "addi_wb", K_IWB, 0);
    step(ORI, 0, 0, 1, "ori_fetch", K_FETCH, 4'd1);
    step(ORI, 0, 0, 0, "ori_decode", K_DECODE, 0);
    step(ORI, 0, 0, 0, "ori_exec", K_IOR, 0);
    step(ORI, 0, 0, 0, "ori_wb", K_IWB, 0);
    step(LUI, 0, 0, 1, "lui_fetch", K_FETCH, 4'd1);
    step(LUI, 0, 0, 0, "lui_decode", K_DECODE, 0);
    step(LUI, 0, 0, 0, "lui_exec", K_ILUI, 0);
    step(LUI, 0, 0, 0, "lui_wb", K_IWB, 0);

    // Jumps
    step(J, 0, 0, 1, "j_fetch", K_FETCH, 4'd1);
    step(J, 0, 0, 0, "j_decode", K_DECODE, 0);
    step(J, 0, 0, 0, "j_jump", K_JUMP, 0);
    step(JAL, 0, 0, 1, "jal_fetch", K_FETCH, 4'd1);
    step(JAL, 0, 0, 0, "jal_decode", K_DECODE, 0);
    step(JAL, 0, 0, 0, "jal_state", K_JAL, 0);
    step(RT, 6'b001000, 0, 1, "jr_fetch", K_FETCH, 4'd1);
    step(RT, 6'b001000, 0, 0, "jr_decode", K_DECODE, 0);
    step(RT, 6'b001000, 0, 0, "jr_state", K_JR, 0);

    // Watchdog restarts per memory state: 5 waits in FETCH then 5 in MEMRD stay under 7
    for (int i = 0; i < 5; i++) step(LW, 0, 0, 0, "wd_fetch_wait", K_FETCH, 4'd0);
    step(LW, 0, 0, 1, "wd_fetch_done", K_FETCH, 4'd1);
    step(LW, 0, 0, 0, "wd_decode", K_DECODE, 0);
    step(LW, 0, 0, 0, "wd_memadr", K_MEMADR, 0);
    for (int i = 0; i < 5; i++) step(LW, 0, 0, 0, "wd_memrd_wait", K_MEMRD, 0);
    step(LW, 0, 0, 1, "wd_memrd_done", K_MEMRD, 0);
    step(LW, 0, 0, 0, "wd_memwb", K_MEMWB, 0);

    // Reset during a MEMWR wait
    step(SW, 0, 0, 1, "rst_sw_fetch", K_FETCH, 4'd1);
    step(SW, 0, 0, 0, "rst_sw_decode", K_DECODE, 0);
    step(SW, 0, 0, 0, "rst_sw_memadr", K_MEMADR, 0);
    step(SW, 0, 0, 0, "rst_sw_memwr_wait", K_MEMWR, 0);
    do_reset("reset_in_memwr");

    // Fetch timeout: 7 waiting cycles then HALT with fault, sticky
    for (int i = 0; i < 7; i++) step(J, 0, 0, 0, "to_fetch_wait", K_FETCH, 4'd0);
    step(J, 0, 0, 1, "to_halt_fault", K_HALT, 4'd1);
    step(J, 0, 0, 1, "to_halt_sticky", K_HALT, 4'd1);
    do_reset("reset_clears_halt");

    // Ready on the seventh waiting cycle wins
    for (int i = 0; i < 6; i++) step(J, 0, 0, 0, "to7_fetch_wait", K_FETCH, 4'd0);
    step(J, 0, 0, 1, "to7_fetch_ready", K_FETCH, 4'd1);
    step(J, 0, 0, 0, "to7_decode", K_DECODE, 0);
    step(J, 0, 0, 0, "to7_jump", K_JUMP, 0);

    // Illegal opcode: dut_a traps, dut_b retires it as a NOP
    push("ill_fetch", 1'b1, K_FETCH, 4'd1);
    step(BAD, 0, 0, 1, "ill_fetch", K_FETCH, 4'd1);
    push("ill_decode", 1'b1, K_DECODE, 0);
    step(BAD, 0, 0, 0, "ill_decode", K_DECODE, 0);
    push("ill_op_nop", 1'b1, K_FETCH, 4'd0);
    step(BAD, 0, 0, 0, "ill_op_halt", K_HALT, 4'd0);
    push("ill_op_nop2", 1'b1, K_FETCH, 4'd0);
    step(BAD, 0, 0, 0, "ill_op_halt2", K_HALT, 4'd0);
    do_reset("reset_after_ill_op");

    // Illegal R-type funct
    step(RT, 6'b000001, 0, 1, "illf_fetch", K_FETCH, 4'd1);
    step(RT, 6'b000001, 0, 0, "illf_decode", K_DECODE, 0);
    push("illf_nop", 1'b1, K_FETCH, 4'd0);
    step(RT, 6'b000001, 0, 0, "illf_halt", K_HALT, 4'd0);

    for (int i = 0; i < 10 && q_exp.size() != 0; i++) @(negedge clk);
    if (q_exp.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", q_exp.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
